lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//   Memory-access stage directly downstream of the execute ALU in the RV32 core.
//   Takes the ALU result as a load/store address, or as plain writeback data, and runs the data-memory bus transaction.
//   Loads are byte-lane aligned and sign/zero extended; non-memory results pass through one register stage.
//   Stalls the upstream execute stage while a bus transaction is outstanding.
// PARAMETERS
//   XLEN        32   datapath width; only 32 is supported
//   RD_W        5    destination register index width
// PORTS
//   clk          in   1     core clock, all state on rising edge
//   rst_n        in   1     asynchronous active-low reset
//   in_valid     in   1     execute stage presents an instruction result
//   in_ready     out  1     stage can accept; high only in IDLE
//   in_op        in   7     opcode: 0000011 load, 0100011 store, 1100011 branch, others ALU
//   in_func      in   3     funct3 of the instruction (load/store width)
//   alu_result   in   32    ALU output: address for load/store, data otherwise
//   store_data   in   32    rs2 value for stores
//   in_rd        in   5     destination register
//   dmem_req     out  1     bus request; held until ack
//   dmem_we      out  1     1 = store
//   dmem_addr    out  32    word address {alu_result[31:2],2'b00}
//   dmem_wdata   out  32    lane-replicated store data
//   dmem_wstrb   out  4     byte enables; 0000 on loads
//   dmem_ack     in   1     bus completion, sampled on clk edge
//   dmem_rdata   in   32    read word, valid with dmem_ack
//   out_valid    out  1     one-cycle pulse: result for writeback
//   out_we       out  1     register write enable for writeback
//   out_rd       out  5     destination register
//   out_data     out  32    writeback data
//   out_err      out  1     misaligned access or illegal funct3, valid with out_valid
// BEHAVIOUR
//   - Reset: state=IDLE; dmem_req, dmem_we, dmem_wstrb, out_valid, out_we, out_err=0; out_rd, out_data, dmem_addr, dmem_wdata=0.
//   - FSM states: IDLE, BUS.
//   - Accept: in_valid & in_ready at edge N. in_ready = (state==IDLE), combinational.
//   - Non-memory op, accepted at N:
//     - out_valid=1 during cycle N+1, out_data=alu_result.
//     - out_we = (in_rd!=0) & op!=branch.
//     - State stays IDLE, giving back-to-back throughput of 1 instruction per cycle.
//   - Load/store legality, checked at acceptance:
//     - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
//     - Legal store funct3: 000 SB, 001 SH, 010 SW.
//     - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
//     - Illegal or misaligned: no bus request; out_valid=1 in N+1 with out_err=1, out_we=0, out_data=alu_result.
//   - Legal load/store:
//     - Enter BUS at N; dmem_req=1 from cycle N+1.
//     - dmem_addr, dmem_we, dmem_wdata and dmem_wstrb are registered and held stable until ack.
//   - Store strobes:
//     - SB: wstrb=0001<<addr[1:0], wdata={4{sd[7:0]}}.
//     - SH: wstrb=0011<<addr[1:0], wdata={2{sd[15:0]}}.
//     - SW: wstrb=1111.
//   - Ack: sampled at edge M (M>=N+1; ack in the first req cycle is legal).
//     - At M: dmem_req drops and state returns to IDLE.
//     - out_valid=1 in cycle M+1; in_ready is high again in cycle M+1.
//   - Load data: select the byte/half at addr[1:0] from dmem_rdata, sign- or zero-extend per funct3.
//     - out_we=(rd!=0) for loads; out_we=0 for stores.
//   - dmem_ack while not in BUS is ignored.
//   - rst_n low at any time, including mid-transaction: the transaction is abandoned and dmem_req falls asynchronously; no out_valid is produced for it.
//   - Writeback always accepts; out_valid is never back-pressured.
// TESTING
//   - ADD result 0x0000_1234, rd=5 -> next cycle out_valid=1, out_data=0x1234, out_we=1, no dmem_req.
//   - LB addr 0x103, rdata 0x80FF_0000, ack after 3 req cycles -> dmem_addr=0x100, out_data=0xFFFF_FF80, out_valid one cycle after ack.
//   - LHU addr 0x102, rdata 0xBEEF_1234 -> out_data=0x0000_BEEF; LW addr 0x102 -> no req, out_err=1, out_we=0.
//   - SB addr 0x201, sd=0xAB -> dmem_we=1, wstrb=0010, wdata=0xABAB_ABAB, out_we=0; in_ready low until ack.
//   - Ack in first req cycle, then back-to-back ALU ops -> one out_valid per instruction, in order, no bubble after return to IDLE.
//   - rst_n pulsed low while dmem_req=1 -> dmem_req=0 immediately, state IDLE, out_valid stays 0.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Memory-access stage behind the execute ALU. ALU results either pass straight
// to writeback through one register stage, or become a load/store address for
// a single data-memory bus transaction. Upstream is stalled while the bus is busy.
//
// Handshake: an instruction is accepted on a rising edge where in_valid and
// in_ready are both high; in_ready is high exactly when the FSM is IDLE. The
// bus side holds dmem_req and all dmem_* payload stable until a rising edge
// that samples dmem_ack high. out_valid is a one-cycle pulse with no ready.
module lsu_mem_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_op,
    input  logic [2:0]      in_func,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [RD_W-1:0] in_rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            out_valid,
    output logic            out_we,
    output logic [RD_W-1:0] out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            out_err
);

    typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

    state_t          state, state_nx;
    logic            accept;
    logic            is_load, is_store, is_branch, is_mem;
    logic            f3_legal, misaligned, mem_go;
    logic [1:0]      off;
    logic [3:0]      wstrb_nx;
    logic [XLEN-1:0] wdata_nx;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] load_data;

    // Per-transaction context kept while the bus is busy
    logic            ld_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [RD_W-1:0] rd_q;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready;
    // Request is a decode of the state register so reset drops it asynchronously
    assign dmem_req = (state == BUS);
    assign off      = alu_result[1:0];

    // Decode opcode, funct3 legality, alignment and store lane placement
    always_comb begin
        is_load    = (in_op == 7'b0000011);
        is_store   = (in_op == 7'b0100011);
        is_branch  = (in_op == 7'b1100011);
        is_mem     = is_load | is_store;
        f3_legal   = 1'b0;
        if (is_load)
            f3_legal = (in_func == 3'b000) | (in_func == 3'b001) | (in_func == 3'b010) |
                       (in_func == 3'b100) | (in_func == 3'b101);
        else if (is_store)
            f3_legal = (in_func == 3'b000) | (in_func == 3'b001) | (in_func == 3'b010);
        // funct3[1:0] encodes access width for every legal load/store
        misaligned = ((in_func[1:0] == 2'b01) & off[0]) |
                     ((in_func[1:0] == 2'b10) & (off != 2'b00));
        mem_go     = is_mem & f3_legal & ~misaligned;
        wstrb_nx   = 4'b1111;
        wdata_nx   = store_data;
        case (in_func[1:0])
            2'b00: begin
                wstrb_nx = 4'b0001 << off;
                wdata_nx = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb_nx = 4'b0011 << off;
                wdata_nx = {2{store_data[15:0]}};
            end
            default: begin
                wstrb_nx = 4'b1111;
                wdata_nx = store_data;
            end
        endcase
    end

    // Select the addressed byte/half from the read word and extend it
    always_comb begin
        lane      = dmem_rdata >> {off_q, 3'b000};
        load_data = dmem_rdata;
        case (f3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_data = {24'd0, lane[7:0]};
            3'b101:  load_data = {16'd0, lane[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: a legal memory op enters BUS, ack returns to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && mem_go) state_nx = BUS;
            BUS:     if (dmem_ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus payload, transaction context and writeback registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= 4'b0000;
            out_valid  <= 1'b0;
            out_we     <= 1'b0;
            out_rd     <= '0;
            out_data   <= '0;
            out_err    <= 1'b0;
            ld_q       <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            rd_q       <= '0;
        end else begin
            out_valid <= 1'b0;
            out_we    <= 1'b0;
            out_err   <= 1'b0;
            if (accept) begin
                if (mem_go) begin
                    dmem_we    <= is_store;
                    dmem_addr  <= {alu_result[XLEN-1:2], 2'b00};
                    dmem_wdata <= is_store ? wdata_nx : '0;
                    dmem_wstrb <= is_store ? wstrb_nx : 4'b0000;
                    ld_q       <= is_load;
                    f3_q       <= in_func;
                    off_q      <= off;
                    rd_q       <= in_rd;
                end else begin
                    // ALU result, or a rejected load/store reported as an error
                    out_valid <= 1'b1;
                    out_rd    <= in_rd;
                    out_data  <= alu_result;
                    out_err   <= is_mem;
                    out_we    <= ~is_mem & ~is_branch & (in_rd != '0);
                end
            end else if (state == BUS && dmem_ack) begin
                out_valid <= 1'b1;
                out_rd    <= rd_q;
                out_data  <= ld_q ? load_data : {dmem_addr[XLEN-1:2], off_q};
                out_we    <= ld_q & (rd_q != '0);
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: one task per scenario, inline comparisons.
module tb_lsu_mem_stage;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_op;
    logic [2:0]  in_func;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  in_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic        out_we;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    lsu_mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_func(in_func),
        .alu_result(alu_result), .store_data(store_data), .in_rd(in_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .out_valid(out_valid), .out_we(out_we),
        .out_rd(out_rd), .out_data(out_data), .out_err(out_err)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge (drive and sample point)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd);
        in_valid   = 1'b1;
        in_op      = op;
        in_func    = f3;
        alu_result = alu;
        store_data = sd;
        in_rd      = rd;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_op    = OP_ALU;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_wstrb, out_valid, out_we, out_err} !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 0",
                     {dmem_req, dmem_we, dmem_wstrb, out_valid, out_we, out_err});
        end
        checks++;
        if ({out_rd, out_data, dmem_addr, dmem_wdata} !== 101'd0) begin
            errors++;
            $display("FAIL reset_data rd=%0d data=%h addr=%h wdata=%h expected 0",
                     out_rd, out_data, dmem_addr, dmem_wdata);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b expected 1", in_ready);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu();
        drive(OP_ALU, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        step();
        idle_in();
        checks++;
        if ({out_valid, out_we, out_err, dmem_req} !== 4'b1100 || out_data !== 32'h1234 || out_rd !== 5'd5) begin
            errors++;
            $display("FAIL alu_add v/we/err/req=%b data=%h rd=%0d expected 1100 1234 5",
                     {out_valid, out_we, out_err, dmem_req}, out_data, out_rd);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL alu_pulse out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_lb();
        int n;
        drive(OP_LOAD, 3'b000, 32'h0000_0103, 32'h0, 5'd7);
        step();
        idle_in();
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_we !== 1'b0 ||
            dmem_wstrb !== 4'b0000 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL lb_req req=%b addr=%h we=%b strb=%b rdy=%b expected 1 100 0 0000 0",
                     dmem_req, dmem_addr, dmem_we, dmem_wstrb, in_ready);
        end
        // two more request cycles, ack in the third
        n = 0;
        while (n < 2) begin
            step();
            n++;
            checks++;
            if (dmem_req !== 1'b1 || out_valid !== 1'b0 || dmem_addr !== 32'h100) begin
                errors++;
                $display("FAIL lb_hold req=%b valid=%b addr=%h expected 1 0 100",
                         dmem_req, out_valid, dmem_addr);
            end
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FF_0000;
        step();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FF80 || out_we !== 1'b1 ||
            out_rd !== 5'd7 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL lb_result valid=%b data=%h we=%b rd=%0d err=%b expected 1 ffffff80 1 7 0",
                     out_valid, out_data, out_we, out_rd, out_err);
        end
        checks++;
        if (dmem_req !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lb_release req=%b rdy=%b expected 0 1", dmem_req, in_ready);
        end
        step();
    endtask

    task automatic test_lhu_lw_misaligned();
        drive(OP_LOAD, 3'b101, 32'h0000_0102, 32'h0, 5'd9);
        step();
        idle_in();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBEEF_1234;
        step();
        dmem_ack   = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_BEEF || out_we !== 1'b1) begin
            errors++;
            $display("FAIL lhu_data valid=%b data=%h we=%b expected 1 0000beef 1",
                     out_valid, out_data, out_we);
        end
        drive(OP_LOAD, 3'b010, 32'h0000_0102, 32'h0, 5'd4);
        step();
        idle_in();
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_we !== 1'b0 ||
            dmem_req !== 1'b0 || out_data !== 32'h102) begin
            errors++;
            $display("FAIL lw_misalign valid=%b err=%b we=%b req=%b data=%h expected 1 1 0 0 102",
                     out_valid, out_err, out_we, dmem_req, out_data);
        end
        // LH signed with rd=0: no register write
        drive(OP_LOAD, 3'b001, 32'h0000_0100, 32'h0, 5'd0);
        step();
        idle_in();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1234_8001;
        step();
        dmem_ack   = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF_8001 || out_we !== 1'b0) begin
            errors++;
            $display("FAIL lh_rd0 valid=%b data=%h we=%b expected 1 ffff8001 0",
                     out_valid, out_data, out_we);
        end
        // illegal load funct3 011
        drive(OP_LOAD, 3'b011, 32'h0000_0200, 32'h0, 5'd3);
        step();
        idle_in();
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_we !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL ld_illegal valid=%b err=%b we=%b req=%b expected 1 1 0 0",
                     out_valid, out_err, out_we, dmem_req);
        end
    endtask

    task automatic test_stores();
        drive(OP_STORE, 3'b000, 32'h0000_0201, 32'h0000_00AB, 5'd1);
        step();
        idle_in();
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wstrb !== 4'b0010 ||
            dmem_wdata !== 32'hABAB_ABAB || dmem_addr !== 32'h200) begin
            errors++;
            $display("FAIL sb_bus req=%b we=%b strb=%b wdata=%h addr=%h expected 1 1 0010 abababab 200",
                     dmem_req, dmem_we, dmem_wstrb, dmem_wdata, dmem_addr);
        end
        step();
        checks++;
        if (in_ready !== 1'b0 || dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL sb_stall rdy=%b req=%b expected 0 1", in_ready, dmem_req);
        end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_we !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL sb_done valid=%b we=%b err=%b rdy=%b expected 1 0 0 1",
                     out_valid, out_we, out_err, in_ready);
        end
        drive(OP_STORE, 3'b001, 32'h0000_0202, 32'h1234_5678, 5'd1);
        step();
        idle_in();
        checks++;
        if (dmem_wstrb !== 4'b1100 || dmem_wdata !== 32'h5678_5678 || dmem_we !== 1'b1) begin
            errors++;
            $display("FAIL sh_bus strb=%b wdata=%h we=%b expected 1100 56785678 1",
                     dmem_wstrb, dmem_wdata, dmem_we);
        end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        drive(OP_STORE, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 5'd1);
        step();
        idle_in();
        checks++;
        if (dmem_wstrb !== 4'b1111 || dmem_wdata !== 32'hDEAD_BEEF || dmem_addr !== 32'h300) begin
            errors++;
            $display("FAIL sw_bus strb=%b wdata=%h addr=%h expected 1111 deadbeef 300",
                     dmem_wstrb, dmem_wdata, dmem_addr);
        end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        // misaligned SH at odd address
        drive(OP_STORE, 3'b001, 32'h0000_0301, 32'h0, 5'd1);
        step();
        idle_in();
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL sh_misalign valid=%b err=%b req=%b expected 1 1 0",
                     out_valid, out_err, dmem_req);
        end
    endtask

    task automatic test_back_to_back();
        int seen;
        int cycles;
        drive(OP_LOAD, 3'b010, 32'h0000_0400, 32'h0, 5'd3);
        exp_q.push_back(32'hCAFE_F00D);
        step();
        idle_in();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        step();
        dmem_ack = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready rdy=%b expected 1", in_ready);
        end
        seen   = 0;
        cycles = 0;
        // Issue three ALU ops on consecutive cycles while draining results
        while (cycles < 8) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra data=%h expected none", out_data);
                end else begin
                    if (out_data !== exp_q[0]) begin
                        errors++;
                        $display("FAIL b2b_order data=%h expected %h", out_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                seen++;
            end
            if (cycles < 3) begin
                drive((cycles == 2) ? OP_BR : OP_ALU, 3'b000, 32'h11 * (cycles + 1), 32'h0, 5'(cycles + 1));
                exp_q.push_back(32'h11 * (cycles + 1));
            end else begin
                idle_in();
            end
            step();
            cycles++;
        end
        checks++;
        if (seen !== 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count seen=%0d left=%0d expected 4 0", seen, exp_q.size());
        end
    endtask

    task automatic test_ack_idle();
        dmem_ack = 1'b1;
        step();
        step();
        dmem_ack = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_idle valid=%b rdy=%b req=%b expected 0 1 0", out_valid, in_ready, dmem_req);
        end
    endtask

    task automatic test_reset_mid();
        drive(OP_LOAD, 3'b010, 32'h0000_0500, 32'h0, 5'd6);
        step();
        idle_in();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async req=%b rdy=%b expected 0 1", dmem_req, in_ready);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1;
        step();
        rst_n    = 1'b1;
        step();
        dmem_ack = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_out valid=%b req=%b expected 0 0", out_valid, dmem_req);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op      = OP_ALU;
        in_func    = 3'b000;
        alu_result = 32'h0;
        store_data = 32'h0;
        in_rd      = 5'd0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        test_reset();
        test_alu();
        test_lb();
        test_lhu_lw_misaligned();
        test_stores();
        test_back_to_back();
        test_ack_idle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
